// File: rtl/encoder_pkg.sv
// Shared encoder definitions: controller states and the quadrature Gray sequence.
package encoder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } enc_state_t;

    // {A,B} in positive physical order; one positive edge advances the index by 1 mod 4.
    localparam logic [3:0][1:0] GRAY_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/encoder_dwell_timer.sv
// Dwell timer: loads a cycle count, counts down to zero and flags the last cycle.
module encoder_dwell_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired,
    output logic         o_running
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign o_expired = (count == W'(1));
    assign o_running = (count != '0);

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: accumulates step requests and replays them as
// A/B Gray edges spaced by a programmable dwell time.
module encoder_emulator
    import encoder_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int PEND_W  = 8,
    parameter int POS_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [DWELL_W-1:0]        i_dwell,
    input  logic                      i_step,
    input  logic                      i_dir,
    input  logic                      i_polarity,
    input  logic                      i_clr_ovf,
    output logic                      o_a,
    output logic                      o_b,
    output logic                      o_busy,
    output logic signed [PEND_W-1:0]  o_pending,
    output logic signed [POS_W-1:0]   o_position,
    output logic                      o_overflow
);

    localparam logic signed [PEND_W+1:0] PEND_MAX = (PEND_W+2)'((1 << (PEND_W-1)) - 1);

    enc_state_t state;
    logic [1:0] phase;
    logic [1:0] phase_next;
    logic       pend_nz;
    logic       pend_pos;
    logic       emit;
    logic       step_drop;
    logic       t_expired;
    logic       t_running;
    logic [DWELL_W-1:0]        dwell_eff;
    logic signed [PEND_W+1:0]  pend_wide;
    logic signed [PEND_W+1:0]  emit_delta;
    logic signed [PEND_W+1:0]  step_delta;
    logic signed [PEND_W+1:0]  pend_base;
    logic signed [PEND_W+1:0]  pend_sum;

    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    always_comb begin
        pend_nz    = (o_pending != '0);
        pend_pos   = pend_nz && !o_pending[PEND_W-1];
        emit       = i_en && pend_nz && ((state == ST_IDLE) || t_expired);
        phase_next = (pend_pos ^ i_polarity) ? phase + 2'd1 : phase - 2'd1;
        dwell_eff  = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

        // Two guard bits keep the +/-1 arithmetic exact before the saturation test.
        pend_wide  = {{2{o_pending[PEND_W-1]}}, o_pending};
        emit_delta = '0;
        if (emit) begin
            emit_delta = pend_pos ? '1 : (PEND_W+2)'(1);
        end
        step_delta = '0;
        if (i_step) begin
            step_delta = i_dir ? (PEND_W+2)'(1) : '1;
        end
        pend_base = pend_wide + emit_delta;
        pend_sum  = pend_base + step_delta;
        step_drop = i_step && ((pend_sum > PEND_MAX) || (pend_sum < -PEND_MAX));
    end

    encoder_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (emit),
        .i_load_val (dwell_eff),
        .o_expired  (t_expired),
        .o_running  (t_running)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            phase      <= 2'd0;
            o_a        <= 1'b0;
            o_b        <= 1'b0;
            o_pending  <= '0;
            o_position <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_pending <= step_drop ? pend_base[PEND_W-1:0] : pend_sum[PEND_W-1:0];

            // A fresh drop outranks a clear request in the same cycle.
            if (step_drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end

            if (emit) begin
                phase        <= phase_next;
                {o_a, o_b}   <= GRAY_SEQ[phase_next];
                o_position   <= pend_pos ? o_position + POS_W'(1) : o_position - POS_W'(1);
            end

            case (state)
                ST_IDLE:  if (emit) state <= ST_DWELL;
                ST_DWELL: if (t_expired && !emit) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = pend_nz || t_running;

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed bench for encoder_emulator with an A/B decoder that tracks every emitted edge.
module tb_encoder_emulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [7:0]        dwell;
    logic              step;
    logic              dir;
    logic              polarity;
    logic              clr_ovf;
    logic              o_a;
    logic              o_b;
    logic              o_busy;
    logic signed [3:0] o_pending;
    logic signed [3:0] o_position;
    logic              o_overflow;

    int checks = 0;
    int errors = 0;

    encoder_emulator #(
        .DWELL_W (8),
        .PEND_W  (4),
        .POS_W   (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_dwell    (dwell),
        .i_step     (step),
        .i_dir      (dir),
        .i_polarity (polarity),
        .i_clr_ovf  (clr_ovf),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_busy     (o_busy),
        .o_pending  (o_pending),
        .o_position (o_position),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Edge monitor: decodes A/B into a physical step count and logs each edge.
    int         cyc = 0;
    logic       rst_q = 1'b1;
    int         dec_pos = 0;
    int         bad_trans = 0;
    logic [1:0] prev_ab = 2'b00;
    logic [1:0] ab_log[$];
    int         cyc_log[$];

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_q = rst;
        end
    end

    initial begin
        logic [1:0] cur;
        forever begin
            @(negedge clk);
            cur = {o_a, o_b};
            if (rst_q) begin
                prev_ab = cur;
            end else if (cur !== prev_ab) begin
                if (cur === fwd(prev_ab)) dec_pos++;
                else if (prev_ab === fwd(cur)) dec_pos--;
                else bad_trans++;
                ab_log.push_back(cur);
                cyc_log.push_back(cyc);
                prev_ab = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (o_busy && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: o_busy=%b after %0d cycles, expected 0", name, o_busy, max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dwell = 8'd0; step = 1'b0; dir = 1'b0;
        polarity = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        checks++;
        if ({o_a, o_b, o_busy, o_overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: a,b,busy,ovf=%b expected 0000", {o_a, o_b, o_busy, o_overflow});
        end
        checks++;
        if (o_pending !== 4'sd0) begin
            errors++; $display("FAIL reset_pending: got %0d expected 0", o_pending);
        end
        checks++;
        if (o_position !== 4'sd0) begin
            errors++; $display("FAIL reset_position: got %0d expected 0", o_position);
        end
        rst = 1'b0;
    endtask

    // Three positive steps at dwell 4; e0..e2 are the expected {A,B} after each edge.
    task automatic test_sequence(input logic pol, input logic [1:0] e0, input logic [1:0] e1,
                                 input logic [1:0] e2);
        int base;
        int step_cyc;
        logic [1:0] exp_ab[3];
        exp_ab[0] = e0; exp_ab[1] = e1; exp_ab[2] = e2;
        do_reset();
        polarity = pol; dwell = 8'd4; en = 1'b1;
        base = ab_log.size();
        step = 1'b1; dir = 1'b1;
        tick();
        step_cyc = cyc;
        tick(); tick();
        step = 1'b0;
        wait_idle("seq_idle", 40);
        checks++;
        if (ab_log.size() - base != 3) begin
            errors++; $display("FAIL seq_edges pol=%b: got %0d expected 3", pol, ab_log.size() - base);
        end
        if (ab_log.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ab_log[base+i] !== exp_ab[i]) begin
                    errors++;
                    $display("FAIL seq_ab%0d pol=%b: got %b expected %b", i, pol, ab_log[base+i], exp_ab[i]);
                end
            end
            checks++;
            if (cyc_log[base] - step_cyc != 1) begin
                errors++; $display("FAIL seq_latency: got %0d expected 1", cyc_log[base] - step_cyc);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (cyc_log[base+i] - cyc_log[base+i-1] != 4) begin
                    errors++;
                    $display("FAIL seq_gap%0d: got %0d expected 4", i, cyc_log[base+i] - cyc_log[base+i-1]);
                end
            end
        end
        checks++;
        if (o_position !== 4'sd3) begin
            errors++; $display("FAIL seq_position: got %0d expected 3", o_position);
        end
        checks++;
        if (o_pending !== 4'sd0) begin
            errors++; $display("FAIL seq_pending: got %0d expected 0", o_pending);
        end
    endtask

    task automatic test_cancel();
        int base;
        do_reset();
        polarity = 1'b0; dwell = 8'd6; en = 1'b1;
        base = ab_log.size();
        step = 1'b1; dir = 1'b1;
        repeat (3) tick();
        dir = 1'b0;
        repeat (2) tick();
        step = 1'b0;
        checks++;
        if (o_pending !== 4'sd0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_mid: pending=%0d busy=%b expected 0 and 1", o_pending, o_busy);
        end
        wait_idle("cancel_idle", 20);
        repeat (10) tick();
        checks++;
        if (ab_log.size() - base != 1) begin
            errors++; $display("FAIL cancel_edges: got %0d expected 1", ab_log.size() - base);
        end
        checks++;
        if (o_position !== 4'sd1) begin
            errors++; $display("FAIL cancel_position: got %0d expected 1", o_position);
        end
    endtask

    task automatic test_polarity_change();
        int base;
        do_reset();
        polarity = 1'b0; dwell = 8'd2; en = 1'b0;
        step = 1'b1; dir = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        base = ab_log.size();
        en = 1'b1;
        tick();
        polarity = 1'b1;
        wait_idle("pol_idle", 20);
        checks++;
        if (ab_log.size() - base != 2) begin
            errors++; $display("FAIL pol_edges: got %0d expected 2", ab_log.size() - base);
        end else begin
            checks++;
            if ({ab_log[base], ab_log[base+1]} !== 4'b1000) begin
                errors++;
                $display("FAIL pol_ab: got %b,%b expected 10,00", ab_log[base], ab_log[base+1]);
            end
        end
        checks++;
        if (o_position !== 4'sd2) begin
            errors++; $display("FAIL pol_position: got %0d expected 2", o_position);
        end
    endtask

    task automatic test_overflow();
        int base;
        int max_gap;
        do_reset();
        polarity = 1'b0; dwell = 8'd0; en = 1'b0;
        step = 1'b1; dir = 1'b1;
        repeat (9) tick();
        step = 1'b0;
        checks++;
        if (o_pending !== 4'sd7 || o_overflow !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat: pending=%0d ovf=%b busy=%b expected 7 1 1", o_pending, o_overflow, o_busy);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", o_overflow);
        end
        clr_ovf = 1'b1; step = 1'b1; dir = 1'b1;
        tick();
        clr_ovf = 1'b0; step = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_pending !== 4'sd7) begin
            errors++;
            $display("FAIL ovf_clr_race: ovf=%b pending=%0d expected 1 7", o_overflow, o_pending);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        base = ab_log.size();
        en = 1'b1;
        wait_idle("ovf_idle", 30);
        checks++;
        if (ab_log.size() - base != 7) begin
            errors++; $display("FAIL ovf_edges: got %0d expected 7", ab_log.size() - base);
        end
        max_gap = 0;
        for (int i = base + 1; i < ab_log.size(); i++) begin
            if (cyc_log[i] - cyc_log[i-1] > max_gap) max_gap = cyc_log[i] - cyc_log[i-1];
        end
        checks++;
        if (max_gap != 1) begin
            errors++; $display("FAIL ovf_dwell0_gap: got %0d expected 1", max_gap);
        end
        checks++;
        if (o_position !== 4'sd7 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_position: position=%0d ovf=%b expected 7 0", o_position, o_overflow);
        end
        step = 1'b1; dir = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        wait_idle("wrap_idle", 20);
        checks++;
        if (o_position !== 4'b1001) begin
            errors++; $display("FAIL pos_wrap: got %b expected 1001", o_position);
        end
        en = 1'b0; step = 1'b1; dir = 1'b0;
        repeat (9) tick();
        step = 1'b0;
        checks++;
        if (o_pending !== -4'sd7 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg_sat: pending=%0d ovf=%b expected -7 1", o_pending, o_overflow);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        polarity = 1'b0; dwell = 8'd8; en = 1'b0;
        step = 1'b1; dir = 1'b1;
        repeat (6) tick();
        step = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_pending !== 4'sd5 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: pending=%0d busy=%b expected 5 1", o_pending, o_busy);
        end
        rst = 1'b1; step = 1'b1; dir = 1'b1; clr_ovf = 1'b1;
        tick();
        checks++;
        if ({o_a, o_b, o_busy, o_overflow} !== 4'b0000 || o_pending !== 4'sd0 || o_position !== 4'sd0) begin
            errors++;
            $display("FAIL rstmid_out: a,b,busy,ovf=%b pending=%0d position=%0d expected 0000 0 0",
                     {o_a, o_b, o_busy, o_overflow}, o_pending, o_position);
        end
        rst = 1'b0; step = 1'b0; clr_ovf = 1'b0;
        base = ab_log.size();
        repeat (30) tick();
        checks++;
        if (ab_log.size() - base != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: edges=%0d busy=%b expected 0 0", ab_log.size() - base, o_busy);
        end
    endtask

    // Steps are spaced 4 cycles apart with dwell <= 3, so each is emitted before the next arrives.
    task automatic test_loopback(input logic pol);
        int base;
        int dbase;
        int bbase;
        int nsteps = 0;
        int net = 0;
        int exp_dec;
        logic d;
        logic [3:0] exp_pos;
        do_reset();
        polarity = pol; dwell = 8'($urandom_range(3, 2)); en = 1'b1;
        base = ab_log.size(); dbase = dec_pos; bbase = bad_trans;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                d = 1'($urandom_range(1, 0));
                step = 1'b1; dir = d;
                nsteps++;
                net += d ? 1 : -1;
            end
            tick();
            step = 1'b0;
            repeat (3) tick();
        end
        wait_idle("loop_idle", 20);
        exp_pos = 4'(net);
        exp_dec = pol ? -net : net;
        checks++;
        if (ab_log.size() - base != nsteps) begin
            errors++; $display("FAIL loop_edges pol=%b: got %0d expected %0d", pol, ab_log.size() - base, nsteps);
        end
        checks++;
        if (dec_pos - dbase != exp_dec || bad_trans != bbase) begin
            errors++;
            $display("FAIL loop_decode pol=%b: got %0d (bad %0d) expected %0d (bad 0)",
                     pol, dec_pos - dbase, bad_trans - bbase, exp_dec);
        end
        checks++;
        if (o_position !== exp_pos || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL loop_position pol=%b: got %b ovf=%b expected %b ovf=0", pol, o_position, o_overflow, exp_pos);
        end
    endtask

    initial begin
        test_reset();
        test_sequence(1'b0, 2'b10, 2'b11, 2'b01);
        test_sequence(1'b1, 2'b01, 2'b11, 2'b10);
        test_cancel();
        test_polarity_change();
        test_overflow();
        test_reset_mid();
        test_loopback(1'b0);
        test_loopback(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_emulator.md
ENCODER_EMULATOR -- requirements
Module: encoder_emulator

Interface
REQ-001 Parameter DWELL_W, default 16, width of the dwell-time input and counter.
REQ-002 Parameter PEND_W, default 8, width of the signed pending-step accumulator.
REQ-003 Parameter POS_W, default 16, width of the signed emitted-position counter.
REQ-004 i_clk  input  1  master clock; single clock domain for all logic.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_en  input  1  enables edge emission; step accumulation continues when low.
REQ-007 i_dwell  input  DWELL_W  minimum cycles between consecutive A/B edges; 0 is treated as 1.
REQ-008 i_step  input  1  single-cycle step request, one step per asserted cycle.
REQ-009 i_dir  input  1  step direction, 1 = positive, 0 = negative; sampled with i_step.
REQ-010 i_polarity  input  1  physical direction inversion.
REQ-011 i_clr_ovf  input  1  clears o_overflow.
REQ-012 o_a  output  1  encoder channel A, registered.
REQ-013 o_b  output  1  encoder channel B, registered.
REQ-014 o_busy  output  1  high while pending != 0 or the dwell timer is running.
REQ-015 o_pending  output  PEND_W  signed count of accepted but not yet emitted steps.
REQ-016 o_position  output  POS_W  signed count of emitted edges (+1 positive, -1 negative).
REQ-017 o_overflow  output  1  sticky flag: a step was dropped due to accumulator saturation.

Function
REQ-018 Positive physical sequence of {A,B} SHALL be 00->10->11->01->00; negative is its reverse; exactly one channel toggles per edge.
REQ-019 Physical direction of an edge SHALL be (sign of pending is positive) XOR i_polarity, with 1 = positive sequence.
REQ-020 Step accepted at edge k SHALL update o_pending by +1/-1 after edge k.
REQ-021 Pending SHALL saturate at +(2^(PEND_W-1)-1) and -(2^(PEND_W-1)-1); a step beyond saturation SHALL be dropped and o_overflow set the next cycle.
REQ-022 Simultaneous step acceptance and edge emission SHALL apply both to pending in the same cycle (net 0, +/-2 change never occurs).
REQ-023 FSM states IDLE and DWELL; IDLE with i_en=1 and pending != 0 SHALL emit one edge, move pending one toward zero, update o_position, load timer, enter DWELL.
REQ-024 In DWELL the timer SHALL decrement each cycle; at expiry, if i_en=1 and pending != 0, emit next edge directly (stay DWELL), else go IDLE.
REQ-025 Edge spacing SHALL be exactly max(i_dwell,1) cycles under continuous pending; i_dwell is sampled at timer load only.
REQ-026 Latency: step sampled at edge k from idle with pending 0 SHALL change o_a/o_b after edge k+1.
REQ-027 i_en low SHALL block new edges only; a running timer continues to expiry.
REQ-028 i_polarity change SHALL affect only edges emitted after it is sampled.
REQ-029 o_position SHALL wrap modulo 2^POS_W.
REQ-030 i_clr_ovf SHALL clear o_overflow; simultaneous new overflow SHALL win (flag stays 1).

Reset
REQ-031 Reset SHALL force o_a=0, o_b=0, o_busy=0, o_pending=0, o_position=0, o_overflow=0, FSM=IDLE, timer=0.
REQ-032 Reset asserted mid-dwell or with pending steps SHALL discard them with no further edges.
REQ-033 Reset SHALL take priority over i_step and i_clr_ovf in the same cycle.

Structure
REQ-034 The FSM state enum and the 4-entry Gray sequence constant SHALL live in shared package encoder_pkg, reused by encoder-related blocks.
REQ-035 The dwell timer SHALL be a sub-module encoder_dwell_timer (load, decrement, expiry flag).
REQ-036 No combinational path SHALL exist from any input to o_a/o_b.

Verification
REQ-037 i_dwell=4, 3 positive steps, i_polarity=0 -> AB 00->10->11->01, edges 4 cycles apart, o_position=3, o_pending=0.
REQ-038 Same with i_polarity=1 -> AB 00->01->11->10, o_position=3.
REQ-039 Pending=+2, then 2 negative steps during DWELL -> pending 0, no further edges, o_busy low after timer expiry.
REQ-040 PEND_W=4, 9 positive steps with i_en=0 -> pending=7, o_overflow=1; i_clr_ovf -> o_overflow=0; i_en=1 -> 7 edges.
REQ-041 Reset asserted mid-dwell with pending=5 -> all outputs 0 next cycle, no edges afterwards.
REQ-042 Loopback into the quadrature reader block, random steps/directions, i_dwell>=2 -> reader step count and polarity match emitted steps exactly.
